instr_fetch_unit: RTL

- Producer side of the opcode interface: fetches 32-bit instruction words from instruction memory and presents each word, its 4-bit opcode and its PC to the decode/control stage.
- Handshakes with instruction memory (req/ack) and with decode (valid/ready).
- Accepts redirects (jump, branch-zero, branch-neg, jump-mem, resolved downstream), flushing the held instruction.

---
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch front end. Requests one word at a time from
//               instruction memory (req/ack), holds the fetched word with its
//               opcode and PC for the decode stage (valid/ready), and restarts
//               fetching from a new PC when a redirect is signalled.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   imem_req     out  fetch request, held high until imem_ack
//   imem_addr    out  word address of the fetch (always the current PC)
//   imem_ack     in   one-cycle pulse, imem_rdata valid in the same cycle
//   imem_rdata   in   instruction word
//   redirect     in   one-cycle pulse, taken jump/branch
//   redirect_pc  in   new PC, valid with redirect
//   out_valid    out  instruction held for decode
//   out_ready    in   decode accepts this cycle
//   out_instr    out  held instruction word
//   out_opcode   out  top four bits of out_instr
//   out_pc       out  address out_instr was fetched from
// ============================================================================
module instr_fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [3:0]        out_opcode,
    output logic [ADDR_W-1:0] out_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FULL = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_instr_q;
    logic [ADDR_W-1:0] out_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            case (state_q)
                // Single dead cycle after reset; redirects are ignored here.
                S_IDLE: begin
                    state_q <= S_REQ;
                end

                S_REQ: begin
                    if (redirect) begin
                        // A word acked in this same cycle belongs to the
                        // wrong path and is dropped.
                        pc_q    <= redirect_pc;
                        state_q <= S_REQ;
                    end else if (imem_ack) begin
                        out_instr_q <= imem_rdata;
                        out_pc_q    <= pc_q;
                        pc_q        <= pc_q + PC_ONE;  // wraps modulo 2^ADDR_W
                        out_valid_q <= 1'b1;
                        state_q     <= S_FULL;
                    end
                end

                S_FULL: begin
                    // A coincident out_ready still counts as consumed; the
                    // redirect only decides where fetching resumes.
                    if (redirect) begin
                        pc_q        <= redirect_pc;
                        out_valid_q <= 1'b0;
                        state_q     <= S_REQ;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_REQ;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs come from state or registers only.
    assign imem_req   = (state_q == S_REQ);
    assign imem_addr  = pc_q;
    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign out_opcode = out_instr_q[DATA_W-1 -: 4];
    assign out_pc     = out_pc_q;

endmodule
`default_nettype wire
